// File: rtl/ariane_pkg.sv
// Shared core types used by the buffer-overflow protection sequencing logic.
// Contents:
//   bop_ctrl_state_e - 3-bit state of bop_guard_ctrl (also exported on state_o)
//   BOP_CAUSE_IL     - cause bit index for an illegal-load alarm
//   BOP_CAUSE_LB     - cause bit index for a load-buffer crash alarm
package ariane_pkg;

  typedef enum logic [2:0] {
    BOP_DISABLED = 3'd0,
    BOP_ARMING   = 3'd1,
    BOP_ARMED    = 3'd2,
    BOP_ALARM    = 3'd3,
    BOP_CLEAR    = 3'd4
  } bop_ctrl_state_e;

  localparam int unsigned BOP_CAUSE_IL = 0;
  localparam int unsigned BOP_CAUSE_LB = 1;

endpackage

// File: rtl/bop_guard_ctrl.sv
// Sequencing controller for bop_unit and its range buffer.
// Keeps detection off during a warm-up window measured in committed
// instructions, converts the unit's sticky violation flags into a one-shot
// exception request with an ack handshake, and holds the range buffer in
// reset for CLEAR_CYCLES cycles after every alarm or flush.
// Ports:
//   clk_i, rst_ni        - core clock, asynchronous active-low reset
//   enable_i             - CSR protection enable (level)
//   instr_commit_i       - one instruction committed this cycle
//   illegal_load_i       - sticky illegal-load flag from bop_unit
//   lb_crash_i           - sticky load-buffer crash flag from bop_unit
//   flush_i              - pipeline flush / context switch
//   ex_ack_i             - commit has taken the exception
//   en_crash_o           - detection enable to bop_unit
//   rst_buf_o            - range-buffer clear to bop_unit
//   ex_valid_o           - exception request
//   ex_cause_o           - bit0 illegal load, bit1 lb crash
//   alarm_count_o        - saturating count of alarms since reset
//   state_o              - current state, debug only
module bop_guard_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned WARMUP_COMMITS = 64,
  parameter int unsigned CLEAR_CYCLES   = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             instr_commit_i,
  input  logic             illegal_load_i,
  input  logic             lb_crash_i,
  input  logic             flush_i,
  input  logic             ex_ack_i,
  output logic             en_crash_o,
  output logic             rst_buf_o,
  output logic             ex_valid_o,
  output logic [1:0]       ex_cause_o,
  output logic [CNT_W-1:0] alarm_count_o,
  output logic [2:0]       state_o
);

  localparam int unsigned WARM_W = (WARMUP_COMMITS < 1) ? 1 : $clog2(WARMUP_COMMITS + 1);
  localparam logic [WARM_W-1:0] WARM_TGT = WARM_W'(WARMUP_COMMITS);
  localparam logic [3:0]        CLR_LOAD = 4'(CLEAR_CYCLES);

  bop_ctrl_state_e   state_q, state_d;
  logic              il_q, il_d;
  logic              lb_q, lb_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [3:0]        clr_q, clr_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  alarm_cnt_q, alarm_cnt_d;
  logic [1:0]        ev;

  // The source flags are sticky, so only their rising edges are events.
  assign ev[BOP_CAUSE_IL] = illegal_load_i & ~il_q;
  assign ev[BOP_CAUSE_LB] = lb_crash_i & ~lb_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    il_d        = illegal_load_i;
    lb_d        = lb_crash_i;
    warm_d      = warm_q;
    clr_d       = clr_q;
    cause_d     = cause_q;
    alarm_cnt_d = alarm_cnt_q;

    if (!enable_i) begin
      // Drops a pending request without ack; the alarm history is kept.
      state_d = BOP_DISABLED;
      cause_d = '0;
    end else begin
      unique case (state_q)
        BOP_DISABLED: begin
          state_d = BOP_ARMING;
          warm_d  = '0;
        end
        BOP_ARMING: begin
          if (flush_i) begin
            warm_d = '0;
          end else if (instr_commit_i) begin
            warm_d = warm_q + 1'b1;
          end
          // Compare the updated count so the window ends on the commit that
          // completes it; with a zero target this exits after one cycle.
          if (warm_d >= WARM_TGT) begin
            state_d = BOP_ARMED;
          end
        end
        BOP_ARMED: begin
          // An event takes priority over a simultaneous flush.
          if (|ev) begin
            state_d = BOP_ALARM;
            cause_d = ev;
            if (alarm_cnt_q != '1) begin
              alarm_cnt_d = alarm_cnt_q + 1'b1;
            end
          end else if (flush_i) begin
            state_d = BOP_CLEAR;
            clr_d   = CLR_LOAD;
            cause_d = '0;
          end
        end
        BOP_ALARM: begin
          cause_d = cause_q | ev;
          if (ex_ack_i) begin
            state_d = BOP_CLEAR;
            clr_d   = CLR_LOAD;
            cause_d = '0;
          end
        end
        BOP_CLEAR: begin
          // Counts CLEAR_CYCLES..1, then rearms without a new warm-up.
          if (clr_q <= 4'd1) begin
            state_d = BOP_ARMED;
          end else begin
            clr_d = clr_q - 1'b1;
          end
        end
        default: state_d = BOP_DISABLED;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= BOP_DISABLED;
      il_q        <= 1'b0;
      lb_q        <= 1'b0;
      warm_q      <= '0;
      clr_q       <= '0;
      cause_q     <= '0;
      alarm_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      il_q        <= il_d;
      lb_q        <= lb_d;
      warm_q      <= warm_d;
      clr_q       <= clr_d;
      cause_q     <= cause_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  // Outputs decode straight from flops, so they are glitch-free at the unit.
  assign en_crash_o    = (state_q == BOP_ARMED);
  assign rst_buf_o     = (state_q == BOP_DISABLED) || (state_q == BOP_CLEAR);
  assign ex_valid_o    = (state_q == BOP_ALARM);
  assign ex_cause_o    = cause_q;
  assign alarm_count_o = alarm_cnt_q;
  assign state_o       = state_q;

endmodule

// File: doc/bop_guard_ctrl.md
# bop_guard_ctrl

Sequencing controller for the buffer-overflow protection unit (`bop_unit`) and its range buffer. It drives `en_crash_i` and `rst_buf_i` on that unit. It holds detection off during a boot warm-up window and turns the unit's sticky violation flags into a one-shot exception request with a handshake toward commit. After each alarm or flush it clears the range buffer for a fixed number of cycles.

## Interface
Parameters:
- `WARMUP_COMMITS`, 64: committed instructions counted in ARMING before detection is enabled.
- `CLEAR_CYCLES`, 4: cycles `rst_buf_o` is held high in CLEAR; legal range 1..15.
- `CNT_W`, 8: width of the alarm counter.

Ports:
- `clk_i` in 1: core clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `enable_i` in 1: CSR protection enable, level.
- `instr_commit_i` in 1: one instruction committed this cycle.
- `illegal_load_i` in 1: `illegal_load_o` from `bop_unit`; sticky level.
- `lb_crash_i` in 1: `lb_crash` from `bop_unit`; sticky level.
- `flush_i` in 1: pipeline flush or context switch.
- `ex_ack_i` in 1: commit has taken the exception.
- `en_crash_o` out 1: to `bop_unit.en_crash_i`.
- `rst_buf_o` out 1: to `bop_unit.rst_buf_i`.
- `ex_valid_o` out 1: exception request.
- `ex_cause_o` out 2: bit0 = illegal load, bit1 = lb crash.
- `alarm_count_o` out `CNT_W`: alarms raised since reset.
- `state_o` out 3: current state, for debug.

## Operation
- Events: the source flags never self-clear, so only rising edges count.
  - `ev_il = illegal_load_i & ~il_q`; `ev_lb = lb_crash_i & ~lb_q`.
  - `il_q` and `lb_q` sample their inputs every cycle.
- States: DISABLED, ARMING, ARMED, ALARM, CLEAR. Encoding is 0..4.
- DISABLED:
  - `rst_buf_o` = 1, `en_crash_o` = 0.
  - `enable_i` = 1 → ARMING; the warm-up counter is loaded with 0.
- ARMING:
  - `en_crash_o` = 0.
  - The counter increments on each `instr_commit_i`.
  - When the counter reaches `WARMUP_COMMITS` → ARMED.
  - `flush_i` resets the counter to 0.
  - With `WARMUP_COMMITS` = 0, exit after one cycle.
- ARMED:
  - `en_crash_o` = 1.
  - Any event → ALARM; cause register loaded with `{ev_lb, ev_il}`; `alarm_count` incremented, saturating at all-ones.
  - Otherwise `flush_i` → CLEAR.
  - Event and flush in the same cycle: the event wins.
- ALARM:
  - `ex_valid_o` = 1, `en_crash_o` = 0.
  - New events are ORed into the cause register.
  - `ex_ack_i` → CLEAR. `ex_valid_o` stays high until acked.
- CLEAR:
  - `rst_buf_o` = 1, `en_crash_o` = 0.
  - Cycle counter runs from `CLEAR_CYCLES` down to 1, then → ARMED (no re-warm-up).
  - The cause register is zeroed on entry.
  - Events and flushes are ignored.
- `enable_i` = 0 in any state → DISABLED next cycle:
  - `ex_valid_o` is dropped without ack.
  - Cause is zeroed; `alarm_count` is kept.

## Timing
- All outputs are registered or decoded directly from the state and cause flops.
- Reset values: state = DISABLED, `rst_buf_o` = 1, `en_crash_o` = 0, `ex_valid_o` = 0, `ex_cause_o` = 0, `alarm_count_o` = 0, `state_o` = 0, `il_q` = `lb_q` = 0.
- Source flag already high when reset is released: `il_q` and `lb_q` come out of reset at 0, so this produces one edge. It is ignored unless the state is ARMED.
- Event seen in ARMED at cycle N → `ex_valid_o` high and `en_crash_o` low at N+1.
- `ex_ack_i` at cycle M in ALARM:
  - `ex_valid_o` low and `rst_buf_o` high at M+1.
  - `rst_buf_o` high for exactly `CLEAR_CYCLES` cycles.
  - `en_crash_o` high at M+1+`CLEAR_CYCLES`.
- `ex_ack_i` outside ALARM is ignored.
- Warm-up count is measured in commits, not cycles.
- Reset mid-operation returns every flop to its reset value immediately (asynchronous).

## Structure
- `bop_ctrl_state_e` (3-bit enum) and the cause bit constants `BOP_CAUSE_IL` = 0 and `BOP_CAUSE_LB` = 1 live in `ariane_pkg`.
- Flat module with no sub-module. Contents: edge flops, FSM, warm-up counter, clear counter, saturating alarm counter.
- Top level instantiates it next to `bop_unit` and wires `en_crash_o`/`rst_buf_o` to it.

## Test plan
- Reset, `enable_i` = 1, `WARMUP_COMMITS` = 4; 3 commits then `flush_i`, then 4 commits → `en_crash_o` rises only after the 4th post-flush commit.
- ARMED, `illegal_load_i` 0→1 → next cycle `ex_valid_o` = 1, `ex_cause_o` = 01, `alarm_count_o` = 1; `ex_ack_i` held off 5 cycles → `ex_valid_o` stays 1.
- In ALARM, `lb_crash_i` rises → `ex_cause_o` = 11. Ack → `rst_buf_o` high for 4 cycles, then ARMED.
- After the previous test, `illegal_load_i` held high → no second alarm.
- Next, `lb_crash_i` drops and rises again → second alarm, count = 2.
- ARMED, event and `flush_i` in the same cycle → ALARM, not CLEAR.
- `CNT_W` = 2, force 5 alarms → `alarm_count_o` saturates at 3.
- `enable_i` dropped mid-ALARM → next cycle `ex_valid_o` = 0, `rst_buf_o` = 1, `state_o` = 0.
- `rst_ni` pulsed mid-CLEAR → `rst_buf_o` = 1 and `state_o` = 0 immediately.
